// File: rtl/axis_acc_share_sched.sv
// Packet-level round-robin scheduler sharing one AXI-Stream accumulator core between
// NUM_SRC requesters: forwards the granted input packet, then returns the core's result packet.
module axis_acc_share_sched #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_SRC*DW-1:0]  S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]     S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]     S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]     S_AXIS_TREADY,
  output logic [DW-1:0]          R_AXIS_TDATA,
  output logic                   R_AXIS_TLAST,
  output logic [NUM_SRC-1:0]     R_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]     R_AXIS_TREADY,
  output logic [DW-1:0]          ACC_S_AXIS_TDATA,
  output logic                   ACC_S_AXIS_TVALID,
  output logic                   ACC_S_AXIS_TLAST,
  input  logic                   ACC_S_AXIS_TREADY,
  input  logic [DW-1:0]          ACC_M_AXIS_TDATA,
  input  logic                   ACC_M_AXIS_TVALID,
  input  logic                   ACC_M_AXIS_TLAST,
  output logic                   ACC_M_AXIS_TREADY,
  output logic [NUM_SRC-1:0]     GRANT,
  output logic                   BUSY,
  output logic [CNT_W-1:0]       DONE_CNT
);

  localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StFwd, StRet} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;

  logic [IW-1:0]      pick_idx;
  logic [DW-1:0]      sel_tdata;
  logic               sel_tvalid;
  logic               sel_tlast;
  logic               fwd_last_fire;
  logic               ret_last_fire;

  // First requester after the last served one, wrapping modulo NUM_SRC.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    logic          found;
    sel   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = IW'((32'(last) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  assign pick_idx   = rr_pick(S_AXIS_TVALID, last_q);
  assign sel_tdata  = S_AXIS_TDATA[gidx_q*DW +: DW];
  assign sel_tvalid = S_AXIS_TVALID[gidx_q];
  assign sel_tlast  = S_AXIS_TLAST[gidx_q];

  assign fwd_last_fire = (state_q == StFwd) && sel_tvalid && ACC_S_AXIS_TREADY && sel_tlast;
  assign ret_last_fire = (state_q == StRet) && ACC_M_AXIS_TVALID && R_AXIS_TREADY[gidx_q] &&
                         ACC_M_AXIS_TLAST;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      StIdle: begin
        if (|S_AXIS_TVALID) begin
          gidx_d           = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          state_d          = StFwd;
        end
      end
      StFwd: begin
        if (fwd_last_fire) state_d = StRet;
      end
      StRet: begin
        if (ret_last_fire) begin
          state_d    = StIdle;
          grant_d    = '0;
          last_d     = gidx_q;
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IW'(NUM_SRC - 1);
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Data paths are pure muxes; only handshakes are gated by state.
  always_comb begin
    S_AXIS_TREADY     = '0;
    R_AXIS_TVALID     = '0;
    R_AXIS_TDATA      = ACC_M_AXIS_TDATA;
    R_AXIS_TLAST      = ACC_M_AXIS_TLAST;
    ACC_S_AXIS_TDATA  = sel_tdata;
    ACC_S_AXIS_TLAST  = sel_tlast;
    ACC_S_AXIS_TVALID = 1'b0;
    ACC_M_AXIS_TREADY = 1'b0;
    case (state_q)
      StFwd: begin
        ACC_S_AXIS_TVALID     = sel_tvalid;
        S_AXIS_TREADY[gidx_q] = ACC_S_AXIS_TREADY;
      end
      StRet: begin
        R_AXIS_TVALID[gidx_q] = ACC_M_AXIS_TVALID;
        ACC_M_AXIS_TREADY     = R_AXIS_TREADY[gidx_q];
      end
      default: ;
    endcase
  end

  assign GRANT    = grant_q;
  assign BUSY     = (state_q != StIdle);
  assign DONE_CNT = done_cnt_q;

endmodule

// File: doc/axis_acc_share_sched.md
Name: axis_acc_share_sched

Overview:
Packet-level round-robin scheduler that shares one AXI-Stream accumulator core (32-bit sum engine, S_AXIS in / M_AXIS out) between NUM_SRC requesters. It grants one requester at a time and forwards that requester's input packet to the core. It then routes the core's whole result packet back to the same requester's return port before re-arbitrating. It sits between the DMA-side stream channels and the accelerator.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
DW, 32, stream data width
CNT_W, 16, width of completed-transaction counter

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
S_AXIS_TDATA  in  NUM_SRC*DW  requester input data, src i at [i*DW +: DW]
S_AXIS_TVALID  in  NUM_SRC  requester input valid
S_AXIS_TLAST  in  NUM_SRC  requester input last
S_AXIS_TREADY  out  NUM_SRC  requester input ready
R_AXIS_TDATA  out  DW  return data, broadcast to all requesters
R_AXIS_TLAST  out  1  return last, broadcast
R_AXIS_TVALID  out  NUM_SRC  return valid, only granted bit may be 1
R_AXIS_TREADY  in  NUM_SRC  return ready per requester
ACC_S_AXIS_TDATA  out  DW  to core input
ACC_S_AXIS_TVALID  out  1  to core input
ACC_S_AXIS_TLAST  out  1  to core input
ACC_S_AXIS_TREADY  in  1  from core input
ACC_M_AXIS_TDATA  in  DW  from core output
ACC_M_AXIS_TVALID  in  1  from core output
ACC_M_AXIS_TLAST  in  1  from core output
ACC_M_AXIS_TREADY  out  1  to core output
GRANT  out  NUM_SRC  one-hot current grant, 0 when idle
BUSY  out  1  1 in FWD or RET
DONE_CNT  out  CNT_W  completed transactions, wraps

Behaviour:
- Reset (async assert, sync-style release on ACLK): state=IDLE, GRANT=0, rr pointer last=NUM_SRC-1 (src0 highest priority first), DONE_CNT=0. All TREADY/TVALID outputs are 0 while ARESET is high and in IDLE.
- States: IDLE, FWD, RET; state, GRANT and pointer are registered; data paths are combinational muxes (zero added latency per beat).
- IDLE: if any S_AXIS_TVALID, pick the first set bit searching last+1, last+2, ... modulo NUM_SRC. Register GRANT and go to FWD. All S_AXIS_TREADY=0 in IDLE; beats are never consumed during arbitration.
- FWD, granted g: ACC_S_AXIS_{TDATA,TLAST,TVALID}=S_AXIS_*[g]. S_AXIS_TREADY[g]=ACC_S_AXIS_TREADY, other bits 0. ACC_M_AXIS_TREADY=0. On a beat with valid&ready&TLAST, go to RET.
- RET: R_AXIS_TDATA/TLAST=ACC_M_AXIS_*. R_AXIS_TVALID[g]=ACC_M_AXIS_TVALID, others 0. ACC_M_AXIS_TREADY=R_AXIS_TREADY[g]. All S_AXIS_TREADY=0. On an accepted beat with TLAST: last<=g, GRANT<=0, DONE_CNT<=DONE_CNT+1 (wrap at 2^CNT_W), go to IDLE.
- Grant is packet-locked: a granted source dropping TVALID mid-packet keeps the grant, and no other source is served. Same in RET for stalls on ACC_M_AXIS_TVALID or R_AXIS_TREADY[g].
- Requests arriving during FWD/RET wait; they are considered in the next IDLE cycle.
- Each transaction has exactly one IDLE cycle between return TLAST and the next grant.
- Single-beat packet (TLAST on first beat) is legal and goes FWD->RET after one beat.
- Return-port TDATA/TLAST are don't-care when the matching TVALID bit is 0.
- Reset asserted mid-FWD/RET aborts immediately to IDLE. Partial packets are dropped with no DONE_CNT increment. Core reset is handled externally.
- BUSY=(state!=IDLE). GRANT one-hot or zero at all times.

Test Plan:
- Single txn: src0 sends 1..8, TLAST on 8th; core sums and returns 8 beats of 36 -> src0 sees 8 beats of 36, TLAST on 8th, other R_AXIS_TVALID stay 0, DONE_CNT=1, one IDLE cycle after.
- Contention: src0..3 all valid at reset release, each sends 8 beats -> grant order 0,1,2,3,0. Each src gets its own sum back, and DONE_CNT=4 after the first four.
- Round-robin skip: last=1, requests on src0 and src3 only -> src3 granted first, then src0.
- Backpressure: ACC_S_AXIS_TREADY toggles 1/0 each cycle in FWD; R_AXIS_TREADY[g] held 0 for 5 cycles in RET -> no beat lost or duplicated, ACC_M_AXIS_TREADY=0 during the stall, and the sum is still correct.
- Packet lock: src1 granted, drops TVALID for 3 cycles mid-packet while src2 is valid -> src2 TREADY stays 0 and src1 keeps the grant until its return TLAST.
- Reset mid-RET: ARESET pulsed after 3 of 8 return beats -> GRANT=0, BUSY=0 and all readies 0 immediately. DONE_CNT keeps its pre-reset value of 0, and src0 is granted first after release.
